// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: ALUOP codes, exception bit
// positions and the access FSM state encoding.
package mem_access_pkg;

  localparam logic [7:0] ALUOP_LB  = 8'b1110_0000;
  localparam logic [7:0] ALUOP_LH  = 8'b1110_0001;
  localparam logic [7:0] ALUOP_LW  = 8'b1110_0011;
  localparam logic [7:0] ALUOP_LBU = 8'b1110_0100;
  localparam logic [7:0] ALUOP_LHU = 8'b1110_0101;
  localparam logic [7:0] ALUOP_SB  = 8'b1110_1000;
  localparam logic [7:0] ALUOP_SH  = 8'b1110_1001;
  localparam logic [7:0] ALUOP_SW  = 8'b1110_1011;

  localparam int unsigned EXC_ADEL_BIT = 28;
  localparam int unsigned EXC_ADES_BIT = 27;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_DATA  = 2'd2,
    ST_DRAIN = 2'd3
  } mem_state_t;

  function automatic logic is_load_op(input logic [7:0] op);
    return (op == ALUOP_LB) || (op == ALUOP_LBU) || (op == ALUOP_LH) ||
           (op == ALUOP_LHU) || (op == ALUOP_LW);
  endfunction

  function automatic logic is_store_op(input logic [7:0] op);
    return (op == ALUOP_SB) || (op == ALUOP_SH) || (op == ALUOP_SW);
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// SRAM-like data request channel between the memory stage (master) and the
// data memory / bus bridge (slave).
interface mem_access_if;
  logic        data_req_o;
  logic        data_wr_o;
  logic [1:0]  data_size_o;
  logic [3:0]  data_wstrb_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic        data_addr_ok_i;
  logic        data_data_ok_i;
  logic [31:0] data_rdata_i;

  modport master (
    output data_req_o, data_wr_o, data_size_o, data_wstrb_o, data_addr_o, data_wdata_o,
    input  data_addr_ok_i, data_data_ok_i, data_rdata_i
  );

  modport slave (
    input  data_req_o, data_wr_o, data_size_o, data_wstrb_o, data_addr_o, data_wdata_o,
    output data_addr_ok_i, data_data_ok_i, data_rdata_i
  );
endinterface

// File: rtl/mem_load_align.sv
// Load data extraction: picks the addressed byte/half from the read word and
// sign- or zero-extends it according to the load opcode.
module mem_load_align
  import mem_access_pkg::*;
(
  input  logic [7:0]  aluop_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] load_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (aluop_i)
      ALUOP_LB:  load_data_o = {{24{byte_sel[7]}}, byte_sel};
      ALUOP_LBU: load_data_o = {24'd0, byte_sel};
      ALUOP_LH:  load_data_o = {{16{half_sel[15]}}, half_sel};
      ALUOP_LHU: load_data_o = {16'd0, half_sel};
      default:   load_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues loads/stores on the SRAM-like channel,
// detects address errors, aligns load data and stalls the front end meanwhile.
module mem_access
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        flush_i,
  input  logic [31:0] pc_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] alu_data_i,
  input  logic [31:0] ram_write_data_i,
  input  logic        regfile_write_enable_i,
  input  logic [4:0]  regfile_write_addr_i,
  input  logic        mem_to_reg_i,
  input  logic [31:0] exception_type_i,
  mem_access_if.master bus,
  output logic        regfile_write_enable_o,
  output logic [4:0]  regfile_write_addr_o,
  output logic [31:0] regfile_write_data_o,
  output logic [31:0] exception_type_o,
  output logic [31:0] bad_vaddr_o,
  output logic [31:0] pc_o,
  output logic        mem_stall_request_o
);

  mem_state_t state, state_next;

  logic        is_load, is_store, misalign, adel, ades, mem_op, load_done, req;
  logic [31:0] exc_vec, load_data;
  logic        unused_mem_to_reg;

  // Load selection is implied by the opcode, so this control is not needed here.
  assign unused_mem_to_reg = mem_to_reg_i;

  assign is_load  = is_load_op(aluop_i);
  assign is_store = is_store_op(aluop_i);

  always_comb begin
    misalign = 1'b0;
    if (aluop_i == ALUOP_LH || aluop_i == ALUOP_LHU || aluop_i == ALUOP_SH)
      misalign = alu_data_i[0];
    else if (aluop_i == ALUOP_LW || aluop_i == ALUOP_SW)
      misalign = |alu_data_i[1:0];
  end

  assign adel = valid_i & is_load & misalign;
  assign ades = valid_i & is_store & misalign;

  always_comb begin
    exc_vec = exception_type_i;
    exc_vec[EXC_ADEL_BIT] = exception_type_i[EXC_ADEL_BIT] | adel;
    exc_vec[EXC_ADES_BIT] = exception_type_i[EXC_ADES_BIT] | ades;
  end

  assign mem_op = valid_i & (is_load | is_store) & (exception_type_i == '0) &
                  ~misalign & ~flush_i;

  assign load_done = (state == ST_DATA) & bus.data_data_ok_i;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // data_ok is only looked at in DATA/DRAIN, so it can never complete an
  // access in the cycle its address is accepted.
  always_comb begin
    state_next = state;
    req        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mem_op) begin
          req        = 1'b1;
          state_next = bus.data_addr_ok_i ? ST_DATA : ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (flush_i) begin
          state_next = ST_IDLE;
        end else begin
          req = 1'b1;
          if (bus.data_addr_ok_i) state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bus.data_data_ok_i) state_next = ST_IDLE;
        else if (flush_i)       state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (bus.data_data_ok_i) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  mem_load_align u_load_align (
    .aluop_i     (aluop_i),
    .addr_i      (alu_data_i[1:0]),
    .rdata_i     (bus.data_rdata_i),
    .load_data_o (load_data)
  );

  always_comb begin
    bus.data_req_o   = req;
    bus.data_wr_o    = is_store;
    bus.data_addr_o  = alu_data_i;
    bus.data_size_o  = 2'd2;
    bus.data_wstrb_o = '0;
    bus.data_wdata_o = ram_write_data_i;
    case (aluop_i)
      ALUOP_LB, ALUOP_LBU: bus.data_size_o = 2'd0;
      ALUOP_LH, ALUOP_LHU: bus.data_size_o = 2'd1;
      ALUOP_SB: begin
        bus.data_size_o  = 2'd0;
        bus.data_wstrb_o = 4'b0001 << alu_data_i[1:0];
        bus.data_wdata_o = {4{ram_write_data_i[7:0]}};
      end
      ALUOP_SH: begin
        bus.data_size_o  = 2'd1;
        bus.data_wstrb_o = alu_data_i[1] ? 4'b1100 : 4'b0011;
        bus.data_wdata_o = {2{ram_write_data_i[15:0]}};
      end
      ALUOP_SW: bus.data_wstrb_o = 4'b1111;
      default: ;
    endcase

    regfile_write_enable_o = regfile_write_enable_i & valid_i & ~flush_i &
                             (exc_vec == '0) & ~(is_load & ~load_done);
    regfile_write_addr_o   = regfile_write_addr_i;
    regfile_write_data_o   = (is_load & load_done) ? load_data : alu_data_i;
    exception_type_o       = exc_vec;
    bad_vaddr_o            = (adel | ades) ? alu_data_i : '0;
    pc_o                   = pc_i;
    mem_stall_request_o    = (mem_op & ~load_done) | (state == ST_DRAIN);

    if (rst) begin
      bus.data_req_o         = 1'b0;
      bus.data_wr_o          = 1'b0;
      bus.data_addr_o        = '0;
      bus.data_size_o        = '0;
      bus.data_wstrb_o       = '0;
      bus.data_wdata_o       = '0;
      regfile_write_enable_o = 1'b0;
      regfile_write_addr_o   = '0;
      regfile_write_data_o   = '0;
      exception_type_o       = '0;
      bad_vaddr_o            = '0;
      pc_o                   = '0;
      mem_stall_request_o    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: drives the pipeline inputs and the memory
// side of the channel cycle by cycle and compares against hand-computed values.
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, flush_i, regfile_write_enable_i, mem_to_reg_i;
  logic [31:0] pc_i, alu_data_i, ram_write_data_i, exception_type_i;
  logic [7:0]  aluop_i;
  logic [4:0]  regfile_write_addr_i;
  logic        regfile_write_enable_o, mem_stall_request_o;
  logic [4:0]  regfile_write_addr_o;
  logic [31:0] regfile_write_data_o, exception_type_o, bad_vaddr_o, pc_o;

  int unsigned checks = 0;
  int unsigned errors = 0;

  mem_access_if bus ();

  mem_access dut (
    .clk                    (clk),
    .rst                    (rst),
    .valid_i                (valid_i),
    .flush_i                (flush_i),
    .pc_i                   (pc_i),
    .aluop_i                (aluop_i),
    .alu_data_i             (alu_data_i),
    .ram_write_data_i       (ram_write_data_i),
    .regfile_write_enable_i (regfile_write_enable_i),
    .regfile_write_addr_i   (regfile_write_addr_i),
    .mem_to_reg_i           (mem_to_reg_i),
    .exception_type_i       (exception_type_i),
    .bus                    (bus),
    .regfile_write_enable_o (regfile_write_enable_o),
    .regfile_write_addr_o   (regfile_write_addr_o),
    .regfile_write_data_o   (regfile_write_data_o),
    .exception_type_o       (exception_type_o),
    .bad_vaddr_o            (bad_vaddr_o),
    .pc_o                   (pc_o),
    .mem_stall_request_o    (mem_stall_request_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic mem(input logic aok, input logic dok, input logic [31:0] rd);
    bus.data_addr_ok_i = aok;
    bus.data_data_ok_i = dok;
    bus.data_rdata_i   = rd;
  endtask

  task automatic clear();
    valid_i = 0; flush_i = 0; pc_i = 0; aluop_i = 0; alu_data_i = 0;
    ram_write_data_i = 0; regfile_write_enable_i = 0; regfile_write_addr_i = 0;
    mem_to_reg_i = 0; exception_type_i = 0;
    mem(0, 0, 0);
  endtask

  task automatic set_op(input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] rt, input logic we);
    valid_i = 1; flush_i = 0; pc_i = 32'hBFC0_0100; aluop_i = op; alu_data_i = addr;
    ram_write_data_i = rt; regfile_write_enable_i = we; regfile_write_addr_i = 5'd3;
    mem_to_reg_i = is_load_op(op); exception_type_i = 0;
  endtask

  initial begin
    clear();
    rst = 1;
    set_op(ALUOP_LW, 32'h0000_1000, 32'h1, 1);
    mem(1, 0, 0);
    smp();
    check("rst_req",   bus.data_req_o, 0);
    check("rst_stall", mem_stall_request_o, 0);
    check("rst_we",    regfile_write_enable_o, 0);
    check("rst_pc",    pc_o, 0);
    check("rst_addr",  bus.data_addr_o, 0);
    adv(); adv();
    rst = 0;
    clear();

    // LW 0x1000: addr_ok in cycle 1, data_ok in cycle 3
    set_op(ALUOP_LW, 32'h0000_1000, 0, 1);
    smp();
    check("lw_c0_req",   bus.data_req_o, 1);
    check("lw_c0_stall", mem_stall_request_o, 1);
    check("lw_c0_we",    regfile_write_enable_o, 0);
    check("lw_c0_size",  bus.data_size_o, 2);
    check("lw_c0_wr",    bus.data_wr_o, 0);
    check("lw_c0_wstrb", bus.data_wstrb_o, 0);
    check("lw_c0_addr",  bus.data_addr_o, 32'h0000_1000);
    adv();
    mem(1, 1, 32'h1111_1111);
    smp();
    check("lw_c1_req",   bus.data_req_o, 1);
    check("lw_c1_stall", mem_stall_request_o, 1);
    check("lw_c1_we",    regfile_write_enable_o, 0);
    adv();
    mem(0, 0, 0);
    smp();
    check("lw_c2_req",   bus.data_req_o, 0);
    check("lw_c2_stall", mem_stall_request_o, 1);
    adv();
    mem(0, 1, 32'hDEAD_BEEF);
    smp();
    check("lw_c3_data",  regfile_write_data_o, 32'hDEAD_BEEF);
    check("lw_c3_we",    regfile_write_enable_o, 1);
    check("lw_c3_waddr", regfile_write_addr_o, 3);
    check("lw_c3_stall", mem_stall_request_o, 0);
    adv(); clear();

    // SB 0x2003
    set_op(ALUOP_SB, 32'h0000_2003, 32'h0000_00A5, 0);
    mem(1, 0, 0);
    smp();
    check("sb_wstrb", bus.data_wstrb_o, 4'b1000);
    check("sb_wdata", bus.data_wdata_o, 32'hA5A5_A5A5);
    check("sb_size",  bus.data_size_o, 0);
    check("sb_wr",    bus.data_wr_o, 1);
    check("sb_req",   bus.data_req_o, 1);
    adv();
    mem(0, 1, 0);
    smp();
    check("sb_done_stall", mem_stall_request_o, 0);
    adv(); clear();

    // SH 0x2002
    set_op(ALUOP_SH, 32'h0000_2002, 32'h0000_1234, 0);
    mem(1, 0, 0);
    smp();
    check("sh_wstrb", bus.data_wstrb_o, 4'b1100);
    check("sh_wdata", bus.data_wdata_o, 32'h1234_1234);
    check("sh_size",  bus.data_size_o, 1);
    adv(); mem(0, 1, 0); adv(); clear();

    // LB / LBU 0x3001, LH 0x4002
    set_op(ALUOP_LB, 32'h0000_3001, 0, 1);
    mem(1, 0, 0);
    adv(); mem(0, 1, 32'h0000_8000);
    smp();
    check("lb_data", regfile_write_data_o, 32'hFFFF_FF80);
    check("lb_we",   regfile_write_enable_o, 1);
    adv(); clear();
    set_op(ALUOP_LBU, 32'h0000_3001, 0, 1);
    mem(1, 0, 0);
    adv(); mem(0, 1, 32'h0000_8000);
    smp();
    check("lbu_data", regfile_write_data_o, 32'h0000_0080);
    adv(); clear();
    set_op(ALUOP_LH, 32'h0000_4002, 0, 1);
    mem(1, 0, 0);
    adv(); mem(0, 1, 32'h8001_0000);
    smp();
    check("lh_data", regfile_write_data_o, 32'hFFFF_8001);
    adv(); clear();

    // Misaligned LW and SH (with a pass-through exception bit)
    set_op(ALUOP_LW, 32'h0000_1002, 0, 1);
    smp();
    check("adel_req",   bus.data_req_o, 0);
    check("adel_exc",   exception_type_o, 32'h1000_0000);
    check("adel_bad",   bad_vaddr_o, 32'h0000_1002);
    check("adel_we",    regfile_write_enable_o, 0);
    check("adel_stall", mem_stall_request_o, 0);
    adv(); clear();
    set_op(ALUOP_SH, 32'h0000_1001, 0, 0);
    exception_type_i = 32'h0000_0400;
    smp();
    check("ades_exc", exception_type_o, 32'h0800_0400);
    check("ades_req", bus.data_req_o, 0);
    check("ades_bad", bad_vaddr_o, 32'h0000_1001);
    adv(); clear();

    // Non-memory op passes ALU result
    set_op(8'h21, 32'h0000_0055, 0, 1);
    smp();
    check("alu_we",    regfile_write_enable_o, 1);
    check("alu_data",  regfile_write_data_o, 32'h0000_0055);
    check("alu_req",   bus.data_req_o, 0);
    check("alu_stall", mem_stall_request_o, 0);
    adv(); clear();

    // Flush in ADDR
    set_op(ALUOP_LW, 32'h0000_7000, 0, 1);
    adv();
    flush_i = 1;
    smp();
    check("fla_req", bus.data_req_o, 0);
    check("fla_we",  regfile_write_enable_o, 0);
    adv(); clear();
    smp();
    check("fla_idle_req",   bus.data_req_o, 0);
    check("fla_idle_stall", mem_stall_request_o, 0);
    adv();

    // Flush in DATA -> DRAIN, then the next op issues from IDLE
    set_op(ALUOP_LW, 32'h0000_5000, 0, 1);
    mem(1, 0, 0);
    adv();
    mem(0, 0, 0);
    flush_i = 1;
    smp();
    check("fld_req", bus.data_req_o, 0);
    check("fld_we",  regfile_write_enable_o, 0);
    adv();
    set_op(ALUOP_LW, 32'h0000_6000, 0, 1);
    smp();
    check("drain_stall", mem_stall_request_o, 1);
    check("drain_req",   bus.data_req_o, 0);
    adv();
    mem(0, 1, 32'h1234_5678);
    smp();
    check("drain_ok_stall", mem_stall_request_o, 1);
    check("drain_ok_we",    regfile_write_enable_o, 0);
    adv();
    mem(1, 0, 0);
    smp();
    check("post_req",  bus.data_req_o, 1);
    check("post_addr", bus.data_addr_o, 32'h0000_6000);
    adv();
    mem(0, 1, 32'h0BAD_F00D);
    smp();
    check("post_data",  regfile_write_data_o, 32'h0BAD_F00D);
    check("post_we",    regfile_write_enable_o, 1);
    check("post_stall", mem_stall_request_o, 0);
    adv(); clear();

    // Reset mid-access abandons without draining
    set_op(ALUOP_LW, 32'h0000_8000, 0, 1);
    mem(1, 0, 0);
    adv();
    rst = 1;
    mem(0, 0, 0);
    smp();
    check("rstm_req",   bus.data_req_o, 0);
    check("rstm_stall", mem_stall_request_o, 0);
    check("rstm_wdata", regfile_write_data_o, 0);
    adv();
    rst = 0;
    clear();
    smp();
    check("rstm_idle_stall", mem_stall_request_o, 0);
    adv();
    set_op(ALUOP_LW, 32'h0000_8000, 0, 1);
    mem(0, 1, 32'h0000_0099);
    smp();
    check("rstm_new_req",   bus.data_req_o, 1);
    check("rstm_new_we",    regfile_write_enable_o, 0);
    check("rstm_new_stall", mem_stall_request_o, 1);
    adv();
    mem(1, 0, 0);
    adv();
    mem(0, 1, 32'h0000_0099);
    smp();
    check("rstm_done_data", regfile_write_data_o, 32'h0000_0099);
    adv(); clear();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
